mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 mux datapath between four requesters. It grants one requester at a time and drives the mux select pair so that the winner's input reaches the mux output. A hold limit bounds how long one owner keeps the mux while others wait. It sits directly in front of the 4:1 mux; its sel outputs connect straight to the mux select inputs.

---
 rtl/mux4_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a 4:1 mux.
// Bounds how long one owner holds the mux while others wait.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic [3:0]    grant,
  output logic          s0,
  output logic          s1,
  output logic          busy,
  output logic [CW-1:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    others;
  logic [3:0]    cand;
  logic          own_req;
  logic          at_max;
  logic [2:0]    pick;
  logic          found;
  logic [1:0]    win;

  // first set bit of r searching from base+1, wrapping; {found, index}
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // last_q is always the current owner while in GRANT
  always_comb begin
    own_req = req[last_q];
    others  = req & ~(4'b0001 << last_q);
    cand    = (state_q == GRANT) ? others : req;
    at_max  = (cnt_q == CW'(MAX_HOLD));
    pick    = rr_pick(cand, last_q);
    found   = pick[2];
    win     = pick[1:0];
  end

  // next-state decision for IDLE/GRANT
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          last_d  = win;
          sel_d   = win;
          grant_d = 4'b0001 << win;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        unique case (1'b1)
          (!own_req && found),
          (own_req && at_max && found): begin
            last_d  = win;
            sel_d   = win;
            grant_d = 4'b0001 << win;
            cnt_d   = CW'(1);
          end
          (!own_req && !found): begin
            state_d = IDLE;
            grant_d = 4'b0000;
            cnt_d   = '0;
          end
          (own_req && at_max && !found): begin
            cnt_d   = cnt_q;
          end
          default: begin
            cnt_d   = cnt_q + CW'(1);
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'b00;
      grant_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign s0       = sel_q[1];
  assign s1       = sel_q[0];
  assign busy     = |grant_q;
  assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter.
// Table of vectors for MAX_HOLD=8, loop for MAX_HOLD=2.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  logic       clk;
  logic       rst_n, rst2_n;
  logic [3:0] req, req2;
  logic [3:0] grant, grant2;
  logic       s0, s1, s0b, s1b;
  logic       busy, busy2;
  logic [3:0] hold_cnt, hold_cnt2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  mux4_rr_arbiter #(.MAX_HOLD(8), .CW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .s0(s0), .s1(s1), .busy(busy), .hold_cnt(hold_cnt)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2), .CW(4)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .grant(grant2),
    .s0(s0b), .s1(s1b), .busy(busy2), .hold_cnt(hold_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic [3:0] c);
    vec_t v;
    v.rst = r; v.req = rq; v.grant = g;
    v.sel = s; v.busy = b; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0;
    rst2_n = 1'b0; req2 = 4'b0;

    // reset
    add(0, 4'b0000, 4'b0000, 2'b00, 0, 0);
    // single request, then release to idle
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 1);
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 2);
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 3);
    add(1, 4'b0000, 4'b0000, 2'b00, 0, 0);
    // leave last=1 in idle, sel retained
    add(1, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(1, 4'b0000, 4'b0000, 2'b01, 0, 0);
    // tie after idle: order 2,3,0,1 -> 3
    add(1, 4'b1001, 4'b1000, 2'b11, 1, 1);
    // release with handover to 1
    add(1, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(1, 4'b0010, 4'b0010, 2'b01, 1, 2);
    // handover 1 -> 0 without dead cycle
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 1);
    for (int c = 2; c <= 8; c++)
      add(1, 4'b0001, 4'b0001, 2'b00, 1, 4'(c));
    // uncontended hold saturates
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 8);
    add(1, 4'b0001, 4'b0001, 2'b00, 1, 8);
    // owner 2, contender 3 arrives at cnt 3
    add(1, 4'b0100, 4'b0100, 2'b10, 1, 1);
    add(1, 4'b0100, 4'b0100, 2'b10, 1, 2);
    add(1, 4'b0100, 4'b0100, 2'b10, 1, 3);
    for (int c = 4; c <= 8; c++)
      add(1, 4'b1100, 4'b0100, 2'b10, 1, 4'(c));
    // forced rotation to 3
    add(1, 4'b1100, 4'b1000, 2'b11, 1, 1);
    for (int c = 2; c <= 5; c++)
      add(1, 4'b1000, 4'b1000, 2'b11, 1, 4'(c));
    // reset mid-grant
    add(0, 4'b1111, 4'b0000, 2'b00, 0, 0);
    add(1, 4'b1111, 4'b0001, 2'b00, 1, 1);
    // owner drops and reasserts: loses turn
    add(1, 4'b1110, 4'b0010, 2'b01, 1, 1);
    add(1, 4'b1111, 4'b0010, 2'b01, 1, 2);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      req   = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", i), grant, tbl[i].grant);
      chk($sformatf("v%0d sel", i), {2'b00, s0, s1},
          {2'b00, tbl[i].sel});
      chk($sformatf("v%0d busy", i), {3'b000, busy},
          {3'b000, tbl[i].busy});
      chk($sformatf("v%0d hold_cnt", i), hold_cnt, tbl[i].cnt);
    end

    // MAX_HOLD=2 with all four requesting
    rst2_n = 1'b0;
    req2   = 4'b1111;
    @(posedge clk);
    #1;
    chk("mh2 reset grant", grant2, 4'b0000);
    rst2_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] o;
      o = 2'((i / 2) % 4);
      @(posedge clk);
      #1;
      chk($sformatf("mh2 c%0d grant", i), grant2, 4'b0001 << o);
      chk($sformatf("mh2 c%0d sel", i), {2'b00, s0b, s1b},
          {2'b00, o});
      chk($sformatf("mh2 c%0d hold_cnt", i), hold_cnt2,
          4'((i % 2) + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
